// File: rtl/mips_pkg.sv
// mips_pkg: opcode/funct constants, ALU-op encoding and the ID/EX bundle types.
package mips_pkg;
  localparam int DATA_W = 32;
  localparam int REG_W = 2;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW = 6'h23;
  localparam logic [5:0] OP_SW = 6'h2B;
  localparam logic [5:0] OP_BEQ = 6'h04;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] F_ADD = 6'h20;
  localparam logic [5:0] F_SUB = 6'h22;
  localparam logic [5:0] F_AND = 6'h24;
  localparam logic [5:0] F_OR = 6'h25;
  localparam logic [5:0] F_SLT = 6'h2A;
  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT} alu_op_e;
  typedef struct packed {
    alu_op_e alu_op;
    logic alu_src;
    logic mem_read;
    logic mem_write;
    logic reg_write;
    logic mem_to_reg;
    logic branch;
    logic illegal;
  } ctrl_t;
  typedef struct packed {
    logic valid;
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [DATA_W-1:0] imm;
    logic [REG_W-1:0] dst;
    ctrl_t ctrl;
  } id_ex_t;
  function automatic ctrl_t illegal_ctrl();
    ctrl_t c;
    c = '0;
    c.illegal = 1'b1;
    return c;
  endfunction
endpackage

// File: rtl/id_stage_if.sv
// id_stage_if: IF-side, register-file and EX-side signals of the decode stage.
interface id_stage_if #(parameter int DW = 32, parameter int RW = 2);
  logic if_valid;
  logic [DW-1:0] if_instr;
  logic [DW-1:0] if_pc;
  logic id_ready;
  logic [RW-1:0] ReadReg1;
  logic [RW-1:0] ReadReg2;
  logic [DW-1:0] ReadData1;
  logic [DW-1:0] ReadData2;
  logic ex_ready;
  logic flush;
  logic ex_valid;
  logic [DW-1:0] ex_pc;
  logic [DW-1:0] ex_rs_data;
  logic [DW-1:0] ex_rt_data;
  logic [DW-1:0] ex_imm;
  logic [RW-1:0] ex_dst;
  logic [2:0] ex_alu_op;
  logic ex_alu_src;
  logic ex_mem_read;
  logic ex_mem_write;
  logic ex_reg_write;
  logic ex_mem_to_reg;
  logic ex_branch;
  logic ex_illegal;
  modport master (
    output if_valid, if_instr, if_pc, ReadData1, ReadData2, ex_ready, flush,
    input id_ready, ReadReg1, ReadReg2, ex_valid, ex_pc, ex_rs_data, ex_rt_data, ex_imm,
    ex_dst, ex_alu_op, ex_alu_src, ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg,
    ex_branch, ex_illegal
  );
  modport slave (
    input if_valid, if_instr, if_pc, ReadData1, ReadData2, ex_ready, flush,
    output id_ready, ReadReg1, ReadReg2, ex_valid, ex_pc, ex_rs_data, ex_rt_data, ex_imm,
    ex_dst, ex_alu_op, ex_alu_src, ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg,
    ex_branch, ex_illegal
  );
endinterface

// File: rtl/id_decoder.sv
// id_decoder: combinational instruction decode into control flags, destination and rt usage.
module id_decoder import mips_pkg::*; #(parameter int RW = REG_W) (
  input  logic [5:0]    opcode,
  input  logic [5:0]    funct,
  input  logic [RW-1:0] rt,
  input  logic [RW-1:0] rd,
  output ctrl_t         ctrl,
  output logic [RW-1:0] dst,
  output logic          rt_used
);
  always_comb begin
    ctrl = '0;
    case (opcode)
      OP_RTYPE: begin
        ctrl.reg_write = 1'b1;
        case (funct)
          F_ADD: ctrl.alu_op = ALU_ADD;
          F_SUB: ctrl.alu_op = ALU_SUB;
          F_AND: ctrl.alu_op = ALU_AND;
          F_OR: ctrl.alu_op = ALU_OR;
          F_SLT: ctrl.alu_op = ALU_SLT;
          default: ctrl = illegal_ctrl();
        endcase
      end
      OP_LW: begin
        ctrl.alu_src = 1'b1;
        ctrl.mem_read = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      OP_SW: begin
        ctrl.alu_src = 1'b1;
        ctrl.mem_write = 1'b1;
      end
      OP_BEQ: begin
        ctrl.alu_op = ALU_SUB;
        ctrl.branch = 1'b1;
      end
      OP_ADDI: begin
        ctrl.alu_src = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      default: ctrl = illegal_ctrl();
    endcase
  end
  assign dst = (opcode == OP_RTYPE) ? rd : rt;
  assign rt_used = (opcode == OP_RTYPE) || (opcode == OP_SW) || (opcode == OP_BEQ);
endmodule

// File: rtl/id_stage.sv
// id_stage: MIPS decode stage with load-use bubble, back-pressure, flush and ID/EX register.
// Define ID_PERF_CNT_EN to build the saturating stall/flush performance counters.
module id_stage import mips_pkg::*; #(parameter int DW = DATA_W, parameter int RW = REG_W) (
  input  logic        clk,
  input  logic        reset,
  id_stage_if.slave   bus,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
);
  logic [RW-1:0] rs, rt, rd, dst;
  logic rt_used, hazard, unused_bits;
  ctrl_t dec;
  id_ex_t r;
  assign rs = bus.if_instr[21 +: RW];
  assign rt = bus.if_instr[16 +: RW];
  assign rd = bus.if_instr[11 +: RW];
  assign unused_bits = ^{bus.if_instr[25:23], bus.if_instr[20:18]};
  id_decoder #(.RW(RW)) u_dec (
    .opcode(bus.if_instr[31:26]),
    .funct(bus.if_instr[5:0]),
    .rt(rt),
    .rd(rd),
    .ctrl(dec),
    .dst(dst),
    .rt_used(rt_used)
  );
  assign hazard = r.valid && r.ctrl.mem_read && bus.if_valid && (r.dst == rs || (rt_used && r.dst == rt));
  assign bus.id_ready = bus.ex_ready && !hazard;
  assign bus.ReadReg1 = rs;
  assign bus.ReadReg2 = rt;
  always_ff @(posedge clk) begin
    if (reset) r <= '0;
    else if (bus.flush) r.valid <= 1'b0;
    else if (bus.ex_ready && hazard) r.valid <= 1'b0;
    else if (bus.ex_ready) r <= '{valid: bus.if_valid, pc: bus.if_pc, rs_data: bus.ReadData1,
                                  rt_data: bus.ReadData2,
                                  imm: {{(DW-16){bus.if_instr[15]}}, bus.if_instr[15:0]},
                                  dst: dst, ctrl: dec};
  end
  assign bus.ex_valid = r.valid;
  assign bus.ex_pc = r.pc;
  assign bus.ex_rs_data = r.rs_data;
  assign bus.ex_rt_data = r.rt_data;
  assign bus.ex_imm = r.imm;
  assign bus.ex_dst = r.dst;
  assign bus.ex_alu_op = r.ctrl.alu_op;
  assign bus.ex_alu_src = r.ctrl.alu_src;
  assign bus.ex_mem_read = r.ctrl.mem_read;
  assign bus.ex_mem_write = r.ctrl.mem_write;
  assign bus.ex_reg_write = r.ctrl.reg_write;
  assign bus.ex_mem_to_reg = r.ctrl.mem_to_reg;
  assign bus.ex_branch = r.ctrl.branch;
  assign bus.ex_illegal = r.ctrl.illegal;
`ifdef ID_PERF_CNT_EN
  // a stall is only counted when the bubble actually enters EX
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (bus.flush && flush_cnt != 16'hFFFF) flush_cnt <= flush_cnt + 16'd1;
      if (!bus.flush && bus.ex_ready && hazard && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
    end
  end
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif
endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: directed plus randomized check of id_stage against a behavioural decode model.
module tb_id_stage;
  logic clk = 1'b0;
  logic reset;
  logic chk_en = 1'b0;
  logic [15:0] stall_cnt, flush_cnt;
  logic [31:0] rf [4];
  int n_cmp = 0;
  int n_bad = 0;
  localparam logic [5:0] FN [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
  localparam logic [5:0] OPS [5] = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h08};
`ifdef ID_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif
  always #5 clk = ~clk;
  id_stage_if bus();
  id_stage dut (.clk(clk), .reset(reset), .bus(bus.slave), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt));
  assign bus.ReadData1 = rf[bus.ReadReg1];
  assign bus.ReadData2 = rf[bus.ReadReg2];

  logic m_valid = 1'b0;
  logic [31:0] m_pc = '0, m_rsd = '0, m_rtd = '0, m_imm = '0;
  logic [1:0] m_dst = '0;
  logic [9:0] m_ctl = '0;
  logic [15:0] m_stall = '0, m_flush = '0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // {illegal, branch, mem_to_reg, reg_write, mem_write, mem_read, alu_src, alu_op[2:0]}
  function automatic logic [9:0] mdec(logic [31:0] i);
    logic [5:0] op;
    op = i[31:26];
    if (op == 6'h00) begin
      for (int k = 0; k < 5; k++)
        if (i[5:0] == FN[k]) return {7'b0001000, 3'(k)};
      return 10'b1000000000;
    end
    if (op == 6'h23) return 10'b0011011000;
    if (op == 6'h2B) return 10'b0000101000;
    if (op == 6'h04) return 10'b0100000001;
    if (op == 6'h08) return 10'b0001001000;
    return 10'b1000000000;
  endfunction

  function automatic logic model_hz();
    logic [31:0] i;
    logic rtu;
    i = bus.if_instr;
    rtu = (i[31:26] == 6'h00) || (i[31:26] == 6'h2B) || (i[31:26] == 6'h04);
    return m_valid && m_ctl[4] && bus.if_valid && (m_dst == i[22:21] || (rtu && m_dst == i[17:16]));
  endfunction

  function automatic logic [9:0] dut_ctl();
    return {bus.ex_illegal, bus.ex_branch, bus.ex_mem_to_reg, bus.ex_reg_write, bus.ex_mem_write,
            bus.ex_mem_read, bus.ex_alu_src, bus.ex_alu_op};
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_valid = 1'b0; m_pc = '0; m_rsd = '0; m_rtd = '0; m_imm = '0; m_dst = '0; m_ctl = '0;
      m_stall = '0; m_flush = '0;
    end else if (bus.flush) begin
      m_valid = 1'b0;
      if (m_flush != 16'hFFFF) m_flush++;
    end else if (bus.ex_ready && model_hz()) begin
      m_valid = 1'b0;
      if (m_stall != 16'hFFFF) m_stall++;
    end else if (bus.ex_ready) begin
      m_valid = bus.if_valid;
      m_pc = bus.if_pc;
      m_rsd = rf[bus.if_instr[22:21]];
      m_rtd = rf[bus.if_instr[17:16]];
      m_imm = 32'($signed(bus.if_instr[15:0]));
      m_ctl = mdec(bus.if_instr);
      m_dst = (bus.if_instr[31:26] == 6'h00) ? bus.if_instr[12:11] : bus.if_instr[17:16];
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("ex_valid", bus.ex_valid, m_valid);
      chk("id_ready", bus.id_ready, bus.ex_ready && !model_hz());
      chk("ReadReg1", bus.ReadReg1, bus.if_instr[22:21]);
      chk("ReadReg2", bus.ReadReg2, bus.if_instr[17:16]);
      if (m_valid) begin
        chk("ex_pc", bus.ex_pc, m_pc);
        chk("ex_rs_data", bus.ex_rs_data, m_rsd);
        chk("ex_rt_data", bus.ex_rt_data, m_rtd);
        chk("ex_imm", bus.ex_imm, m_imm);
        chk("ex_ctrl", dut_ctl(), m_ctl);
        if (m_ctl[6]) chk("ex_dst", bus.ex_dst, m_dst);
      end
      chk("stall_cnt", stall_cnt, PERF ? m_stall : 16'd0);
      chk("flush_cnt", flush_cnt, PERF ? m_flush : 16'd0);
    end
  end

  task automatic drive(logic v, logic [31:0] i, logic [31:0] p);
    bus.if_valid = v;
    bus.if_instr = i;
    bus.if_pc = p;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rnd_instr();
    logic [31:0] r;
    int k;
    r = $urandom();
    k = $urandom_range(0, 7);
    if (k <= 4) r[31:26] = OPS[k];
    if (k == 0) r[5:0] = FN[$urandom_range(0, 4)];
    if (k == 5) r[31:26] = 6'h00;
    return r;
  endfunction

  initial begin
    for (int i = 0; i < 4; i++) rf[i] = $urandom();
    reset = 1'b1;
    drive(1'b0, '0, '0);
    bus.ex_ready = 1'b1;
    bus.flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ex_valid", bus.ex_valid, 0);
    chk("rst_ex_imm", bus.ex_imm, 0);
    chk("rst_ex_pc", bus.ex_pc, 0);
    chk("rst_ctrl", dut_ctl(), 0);
    chk("rst_stall", stall_cnt, 0);
    chk("rst_flush", flush_cnt, 0);
    chk("rst_id_ready", bus.id_ready, 1);
    reset = 1'b0;
    chk_en = 1'b1;
    drive(1'b1, 32'h2002FFFC, 32'h100);
    tick();
    chk("addi_valid", bus.ex_valid, 1);
    chk("addi_imm", bus.ex_imm, 32'hFFFFFFFC);
    chk("addi_dst", bus.ex_dst, 2);
    chk("addi_ctrl", dut_ctl(), 10'b0001001000);
    drive(1'b1, 32'h8C410000, 32'h104);
    tick();
    chk("lw_mem_read", bus.ex_mem_read, 1);
    chk("lw_dst", bus.ex_dst, 1);
    drive(1'b1, 32'h00221820, 32'h108);
    #1;
    chk("lu_id_ready", bus.id_ready, 0);
    tick();
    chk("lu_bubble", bus.ex_valid, 0);
    chk("lu_ready_again", bus.id_ready, 1);
    tick();
    chk("lu_add_valid", bus.ex_valid, 1);
    chk("lu_add_dst", bus.ex_dst, 3);
    chk("lu_add_pc", bus.ex_pc, 32'h108);
    chk("lu_stall_cnt", stall_cnt, PERF ? 1 : 0);
    drive(1'b1, 32'hAC410000, 32'h10C);
    tick();
    drive(1'b1, 32'h00221820, 32'h110);
    #1;
    chk("sw_no_stall", bus.id_ready, 1);
    tick();
    chk("sw_add_dst", bus.ex_dst, 3);
    drive(1'b1, 32'h2002FFFC, 32'h200);
    bus.ex_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("hold_pc", bus.ex_pc, 32'h110);
      chk("hold_id_ready", bus.id_ready, 0);
    end
    bus.ex_ready = 1'b1;
    tick();
    chk("release_pc", bus.ex_pc, 32'h200);
    chk("release_imm", bus.ex_imm, 32'hFFFFFFFC);
    drive(1'b1, 32'hFC000000, 32'h300);
    tick();
    chk("illegal_valid", bus.ex_valid, 1);
    chk("illegal_ctrl", dut_ctl(), 10'b1000000000);
    drive(1'b1, 32'h8C410000, 32'h304);
    tick();
    drive(1'b1, 32'h00221820, 32'h308);
    bus.flush = 1'b1;
    tick();
    chk("fh_valid", bus.ex_valid, 0);
    chk("fh_flush_cnt", flush_cnt, PERF ? 1 : 0);
    chk("fh_stall_cnt", stall_cnt, PERF ? 1 : 0);
    bus.flush = 1'b0;
    repeat (3000) begin
      tick();
      reset = ($urandom_range(0, 99) == 0);
      drive(1'($urandom_range(0, 3) != 0), rnd_instr(), $urandom());
      bus.ex_ready = ($urandom_range(0, 4) != 0);
      bus.flush = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 3) == 0) rf[$urandom_range(0, 3)] = $urandom();
    end
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
